// File: rtl/hx8352_pkg.sv
// Shared HX8352 window-scheduler definitions: register map, window field layout, FSM encoding.
// Helpers turn a latched window into the 17-word register preamble.
package hx8352_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_REG, S_HOLD, S_WAIT, S_PIX, S_PHOLD, S_PWAIT
  } state_t;

  localparam logic [7:0] REG_COL_START_HI = 8'h02;
  localparam logic [7:0] REG_COL_START_LO = 8'h03;
  localparam logic [7:0] REG_COL_END_HI   = 8'h04;
  localparam logic [7:0] REG_COL_END_LO   = 8'h05;
  localparam logic [7:0] REG_ROW_START_HI = 8'h06;
  localparam logic [7:0] REG_ROW_START_LO = 8'h07;
  localparam logic [7:0] REG_ROW_END_HI   = 8'h08;
  localparam logic [7:0] REG_ROW_END_LO   = 8'h09;
  localparam logic [7:0] REG_GRAM_WR      = 8'h22;

  localparam int WIN_X0_LSB = 26;
  localparam int WIN_Y0_LSB = 17;
  localparam int WIN_X1_LSB = 9;
  localparam int WIN_Y1_LSB = 0;
  localparam logic [4:0] REG_WORDS = 5'd17;

  typedef struct packed {
    logic [7:0] x0;
    logic [8:0] y0;
    logic [7:0] x1;
    logic [8:0] y1;
  } win_t;

  function automatic win_t unpack_win(input logic [33:0] w);
    win_t r;
    r.x0 = w[WIN_X0_LSB +: 8];
    r.y0 = w[WIN_Y0_LSB +: 9];
    r.x1 = w[WIN_X1_LSB +: 8];
    r.y1 = w[WIN_Y1_LSB +: 9];
    return r;
  endfunction

  // Even idx = register index word, odd idx = its data byte, idx 16 = GRAM write index.
  function automatic logic [15:0] reg_word(input logic [4:0] idx, input win_t w);
    logic [7:0] a;
    logic [7:0] b;
    case (idx[3:1])
      3'd0:    begin a = REG_COL_START_HI; b = 8'h00;            end
      3'd1:    begin a = REG_COL_START_LO; b = w.x0;             end
      3'd2:    begin a = REG_COL_END_HI;   b = 8'h00;            end
      3'd3:    begin a = REG_COL_END_LO;   b = w.x1;             end
      3'd4:    begin a = REG_ROW_START_HI; b = {7'd0, w.y0[8]};  end
      3'd5:    begin a = REG_ROW_START_LO; b = w.y0[7:0];        end
      3'd6:    begin a = REG_ROW_END_HI;   b = {7'd0, w.y1[8]};  end
      default: begin a = REG_ROW_END_LO;   b = w.y1[7:0];        end
    endcase
    if (idx[4])
      return {8'h00, REG_GRAM_WR};
    else if (!idx[0])
      return {8'h00, a};
    else
      return {8'h00, b};
  endfunction

endpackage

// File: rtl/hx8352_window_scheduler_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant when enabled, no added latency.
// A tie goes to the requester not granted last; the pointer only moves on an actual grant.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
      if (|gnt) last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else      last_q <= last_d;
  end

endmodule

// File: rtl/hx8352_window_scheduler.sv
// Arbitrates two window jobs onto one HX8352 bus: 17 register words then one word per pixel.
// Every bus word waits for lcd_busy low, so one word per 3+ cycles; pixels stall via px_ready.
module hx8352_window_scheduler
  import hx8352_pkg::*;
#(
  parameter int unsigned X_MAX = 239,
  parameter int unsigned Y_MAX = 399
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        lcd_busy,
  output logic        lcd_wr_en,
  output logic        lcd_rs,
  output logic [15:0] lcd_data,
  input  logic [1:0]  req,
  input  logic [33:0] win0,
  input  logic [33:0] win1,
  output logic [1:0]  gnt,
  input  logic [15:0] px_data0,
  input  logic [15:0] px_data1,
  input  logic [1:0]  px_valid,
  output logic [1:0]  px_ready,
  output logic [1:0]  done,
  output logic [1:0]  err
);

  state_t      state_q, state_d;
  win_t        win_q, win_d, win_in;
  logic [4:0]  widx_q, widx_d;
  logic [16:0] count_q, count_d;
  logic        sel_q, sel_d;
  logic        lcd_wr_en_q, lcd_wr_en_d, lcd_rs_q, lcd_rs_d;
  logic [15:0] lcd_data_q, lcd_data_d;
  logic [1:0]  gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic [1:0]  arb_gnt, sel_oh;
  logic        win_bad;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  ((state_q == S_IDLE) && init_done),
    .gnt (arb_gnt)
  );

  assign win_in  = arb_gnt[1] ? unpack_win(win1) : unpack_win(win0);
  assign sel_oh  = sel_q ? 2'b10 : 2'b01;
  assign win_bad = (win_q.x0 > win_q.x1) || (win_q.y0 > win_q.y1) ||
                   (32'(win_q.x1) > X_MAX) || (32'(win_q.y1) > Y_MAX);

  assign px_ready  = (state_q == S_PIX && !lcd_busy) ? sel_oh : 2'b00;
  assign lcd_wr_en = lcd_wr_en_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_data  = lcd_data_q;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    widx_d      = widx_q;
    count_d     = count_q;
    sel_d       = sel_q;
    lcd_wr_en_d = 1'b0;
    lcd_rs_d    = lcd_rs_q;
    lcd_data_d  = lcd_data_q;
    gnt_d       = 2'b00;
    done_d      = 2'b00;
    err_d       = 2'b00;
    // Losing controller init kills any job, including one still checking its window.
    if (state_q != S_IDLE && !init_done) begin
      state_d = S_IDLE;
      err_d   = sel_oh;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (|arb_gnt) begin
            gnt_d   = arb_gnt;
            sel_d   = arb_gnt[1];
            win_d   = win_in;
            widx_d  = 5'd0;
            count_d = (17'(win_in.x1) - 17'(win_in.x0) + 17'd1) *
                      (17'(win_in.y1) - 17'(win_in.y0) + 17'd1);
            state_d = S_REG;
          end
        end
        S_REG: begin
          if (win_bad) begin
            err_d   = sel_oh;
            state_d = S_IDLE;
          end else if (!lcd_busy) begin
            lcd_wr_en_d = 1'b1;
            lcd_rs_d    = widx_q[0];
            lcd_data_d  = reg_word(widx_q, win_q);
            widx_d      = widx_q + 5'd1;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: state_d = S_WAIT;
        S_WAIT: begin
          if (!lcd_busy) state_d = (widx_q == REG_WORDS) ? S_PIX : S_REG;
        end
        S_PIX: begin
          if (px_valid[sel_q] && !lcd_busy) begin
            lcd_wr_en_d = 1'b1;
            lcd_rs_d    = 1'b1;
            lcd_data_d  = sel_q ? px_data1 : px_data0;
            count_d     = count_q - 17'd1;
            state_d     = S_PHOLD;
          end
        end
        S_PHOLD: begin
          if (count_q == 17'd0) begin
            done_d  = sel_oh;
            state_d = S_IDLE;
          end else begin
            state_d = S_PWAIT;
          end
        end
        S_PWAIT: begin
          if (!lcd_busy) state_d = S_PIX;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      win_q       <= '0;
      widx_q      <= 5'd0;
      count_q     <= 17'd0;
      sel_q       <= 1'b0;
      lcd_wr_en_q <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_data_q  <= 16'h0000;
      gnt_q       <= 2'b00;
      done_q      <= 2'b00;
      err_q       <= 2'b00;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      widx_q      <= widx_d;
      count_q     <= count_d;
      sel_q       <= sel_d;
      lcd_wr_en_q <= lcd_wr_en_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_data_q  <= lcd_data_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_hx8352_window_scheduler.sv
// Bench for hx8352_window_scheduler: directed and random jobs against a word-list reference model.
// A small LCD/pixel-source environment runs on the falling edge; checks happen there too.
module tb_hx8352_window_scheduler;

  localparam int XM = 39;
  localparam int YM = 49;

  logic        clk = 1'b0, rst = 1'b0, init_done = 1'b0, lcd_busy = 1'b0;
  logic        lcd_wr_en, lcd_rs;
  logic [15:0] lcd_data;
  logic [1:0]  req = 2'b00, gnt, px_ready, done, err;
  logic [33:0] win0 = '0, win1 = '0;
  logic [15:0] px_data0 = '0, px_data1 = '0;
  logic [1:0]  px_valid = 2'b00, acc = 2'b00;

  int checks = 0, errors = 0, cyc = 0;
  int busy_mode = 0, valid_mode = 0, busy_cnt = 0;
  int pix_idx[2] = '{0, 0};
  int gap_on = 0, gap_req = 0, gap_at = 0, gap_cnt = 0, gap_wr = 0;
  bit gap_prev = 1'b0;
  logic [16:0] mon_words[$];
  logic [16:0] exp_q[$];
  int wx0[2], wy0[2], wx1[2], wy1[2];
  int last = 1, prev_end = -10;

  hx8352_window_scheduler #(.X_MAX(XM), .Y_MAX(YM)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .lcd_busy(lcd_busy),
    .lcd_wr_en(lcd_wr_en), .lcd_rs(lcd_rs), .lcd_data(lcd_data),
    .req(req), .win0(win0), .win1(win1), .gnt(gnt),
    .px_data0(px_data0), .px_data1(px_data1), .px_valid(px_valid), .px_ready(px_ready),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] pix_val(input int i, input int k);
    return 16'((k + 1) * 40503) ^ ((i == 1) ? 16'h5A5A : 16'h0000);
  endfunction

  // LCD busy model, word monitor and pixel sources.
  always @(negedge clk) begin
    if (lcd_wr_en === 1'b1) begin
      mon_words.push_back({lcd_rs, lcd_data});
      if (gap_prev) gap_wr++;
    end
    if (busy_cnt > 0) busy_cnt--;
    if (lcd_wr_en === 1'b1 && busy_mode == 1) busy_cnt = 2;
    lcd_busy = (busy_cnt != 0) || (busy_mode == 2 && $urandom_range(3) == 0);
    for (int i = 0; i < 2; i++) if (acc[i]) pix_idx[i]++;
    gap_prev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (gap_on != 0 && i == gap_req && pix_idx[i] == gap_at && gap_cnt < 50) begin
        px_valid[i] = 1'b0;
        gap_cnt++;
        gap_prev = 1'b1;
      end else begin
        px_valid[i] = (valid_mode == 0) || ($urandom_range(1) == 0);
      end
    end
    px_data0 = pix_val(0, pix_idx[0]);
    px_data1 = pix_val(1, pix_idx[1]);
    #1;
    acc = px_valid & px_ready;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_win(input int i, input int x0, input int y0, input int x1, input int y1);
    logic [33:0] w;
    wx0[i] = x0; wy0[i] = y0; wx1[i] = x1; wy1[i] = y1;
    w = {8'(x0), 9'(y0), 8'(x1), 9'(y1)};
    if (i == 0) win0 = w; else win1 = w;
  endtask

  function automatic bit win_ok(input int i);
    return wx0[i] <= wx1[i] && wy0[i] <= wy1[i] && wx1[i] <= XM && wy1[i] <= YM;
  endfunction

  // Expected bus words: 8 register index/data pairs (hi byte then lo byte), GRAM index, pixels.
  task automatic build_exp(input int i, input int base);
    int v[4];
    exp_q.delete();
    v[0] = wx0[i]; v[1] = wx1[i]; v[2] = wy0[i]; v[3] = wy1[i];
    for (int r = 0; r < 4; r++) begin
      exp_q.push_back({1'b0, 16'(2 + 2 * r)});
      exp_q.push_back({1'b1, 16'(v[r] / 256)});
      exp_q.push_back({1'b0, 16'(3 + 2 * r)});
      exp_q.push_back({1'b1, 16'(v[r] % 256)});
    end
    exp_q.push_back({1'b0, 16'h0022});
    for (int k = 0; k < (wx1[i] - wx0[i] + 1) * (wy1[i] - wy0[i] + 1); k++)
      exp_q.push_back({1'b1, pix_val(i, base + k)});
  endtask

  task automatic serve(input logic [1:0] rq);
    logic [1:0] exp_g, oh;
    int i, t, gcyc, mbase, n;
    bit ok;
    req = rq;
    while (req != 2'b00) begin
      exp_g = (req == 2'b11) ? ((last == 1) ? 2'b01 : 2'b10) : req;
      t = 0;
      while (gnt == 2'b00 && t < 60) begin @(negedge clk); t++; end
      chk("gnt", 32'(gnt), 32'(exp_g));
      if (gnt == 2'b00) begin req = 2'b00; return; end
      gcyc = cyc;
      i = gnt[1] ? 1 : 0;
      oh = gnt;
      last = i;
      req[i] = 1'b0;
      chk("gnt_after_end", (gcyc > prev_end) ? 1 : 0, 1);
      mbase = mon_words.size();
      ok = win_ok(i);
      if (ok) build_exp(i, pix_idx[i]); else exp_q.delete();
      n = exp_q.size();
      @(negedge clk);
      t = 1;
      while (done == 2'b00 && err == 2'b00 && t < 300 + n * 12) begin @(negedge clk); t++; end
      prev_end = cyc;
      chk("done", 32'(done), ok ? 32'(oh) : 0);
      chk("err", 32'(err), ok ? 0 : 32'(oh));
      if (!ok) chk("err_latency", cyc - gcyc, 1);
      chk("nwords", mon_words.size() - mbase, n);
      for (int k = 0; k < n && mbase + k < mon_words.size(); k++)
        chk($sformatf("word%0d", k), 32'(mon_words[mbase + k]), 32'(exp_q[k]));
    end
  endtask

  initial begin
    int t, ng, mbase, x0, y0, x1, y1, tmp;
    logic [1:0] rq;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(lcd_wr_en), 0);
    chk("rst_rs", 32'(lcd_rs), 0);
    chk("rst_data", 32'(lcd_data), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_px_ready", 32'(px_ready), 0);
    chk("rst_done_err", 32'({done, err}), 0);
    rst = 1'b1;

    // No grant before the controller is initialised
    req = 2'b01;
    ng = 0;
    repeat (6) begin @(negedge clk); if (gnt != 2'b00) ng++; end
    chk("no_gnt_before_init", ng, 0);
    init_done = 1'b1;

    // 2x2 window with a 2-cycle busy after every word
    busy_mode = 1;
    set_win(0, 0, 0, 1, 1);
    serve(2'b01);

    // Simultaneous requests from reset: requester 0 first
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last = 1;
    busy_mode = 2;
    valid_mode = 1;
    set_win(0, 3, 4, 3, 4);
    set_win(1, 7, 8, 7, 8);
    serve(2'b11);

    // Rejected windows and the legal corner
    busy_mode = 0;
    valid_mode = 0;
    set_win(1, 10, 0, 5, 0);      serve(2'b10);
    set_win(0, 0, 5, 0, 4);       serve(2'b01);
    set_win(1, 0, 0, XM + 1, 0);  serve(2'b10);
    set_win(0, 0, 0, 0, YM + 1);  serve(2'b01);
    set_win(1, XM, YM, XM, YM);   serve(2'b10);

    // Full screen at X_MAX/Y_MAX
    set_win(0, 0, 0, XM, YM);
    serve(2'b01);

    // 50-cycle pixel starvation mid-stream
    set_win(1, 2, 3, 9, 6);
    gap_req = 1;
    gap_at = pix_idx[1] + 10;
    gap_on = 1;
    serve(2'b10);
    gap_on = 0;
    chk("gap_length", gap_cnt, 50);
    chk("gap_no_words", gap_wr, 0);

    // Random jobs
    for (int it = 0; it < 10; it++) begin
      busy_mode = $urandom_range(2);
      valid_mode = $urandom_range(1);
      for (int i = 0; i < 2; i++) begin
        x0 = $urandom_range(XM); x1 = x0 + $urandom_range(4);
        y0 = $urandom_range(YM); y1 = y0 + $urandom_range(4);
        if ($urandom_range(4) == 0) begin tmp = x0; x0 = x1; x1 = tmp; end
        set_win(i, x0, y0, x1, y1);
      end
      rq = 2'($urandom_range(1, 3));
      serve(rq);
    end

    // init_done dropped during pixel streaming
    busy_mode = 0;
    valid_mode = 0;
    set_win(0, 0, 0, 9, 9);
    req = 2'b01;
    t = 0;
    while (gnt == 2'b00 && t < 60) begin @(negedge clk); t++; end
    chk("abort_gnt", 32'(gnt), 32'(2'b01));
    last = 0;
    req = 2'b00;
    t = 0;
    while (px_ready == 2'b00 && t < 300) begin @(negedge clk); t++; end
    chk("abort_in_pix", 32'(px_ready), 32'(2'b01));
    init_done = 1'b0;
    @(negedge clk);
    chk("abort_px_ready", 32'(px_ready), 0);
    chk("abort_err", 32'(err), 32'(2'b01));
    chk("abort_no_word", 32'(lcd_wr_en), 0);
    @(negedge clk);
    chk("abort_err_pulse", 32'(err), 0);
    prev_end = cyc;
    req = 2'b10;
    ng = 0;
    repeat (6) begin @(negedge clk); if (gnt != 2'b00) ng++; end
    chk("no_gnt_without_init", ng, 0);
    init_done = 1'b1;
    set_win(1, 1, 1, 2, 2);
    serve(2'b10);

    // Reset in the middle of the register preamble
    busy_mode = 1;
    set_win(0, 0, 0, 3, 3);
    req = 2'b01;
    t = 0;
    while (gnt == 2'b00 && t < 60) begin @(negedge clk); t++; end
    chk("rst_job_gnt", 32'(gnt), 32'(2'b01));
    req = 2'b00;
    mbase = mon_words.size();
    t = 0;
    while (mon_words.size() - mbase < 3 && t < 200) begin @(negedge clk); t++; end
    chk("rst_job_in_reg", (mon_words.size() - mbase >= 3) ? 1 : 0, 1);
    rst = 1'b0;
    #1;
    chk("rst_async_outputs", 32'({lcd_wr_en, lcd_rs, lcd_data, gnt, px_ready, done, err}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    last = 1;
    prev_end = cyc;
    mbase = mon_words.size();
    repeat (40) @(negedge clk);
    chk("no_words_after_rst", mon_words.size() - mbase, 0);

    // Pointer is back to its reset value
    busy_mode = 0;
    set_win(0, 5, 5, 6, 6);
    set_win(1, 8, 8, 8, 9);
    serve(2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hx8352_window_scheduler.md
HX8352_WINDOW_SCHEDULER -- requirements
Module: hx8352_window_scheduler

Interface
REQ-001 SHALL have parameter X_MAX, default 239, meaning the largest legal column.
REQ-002 SHALL have parameter Y_MAX, default 399, meaning the largest legal row.
REQ-003 SHALL have port clk  input  1  single system clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port init_done  input  1  LCD controller initialisation complete.
REQ-006 SHALL have port lcd_busy  input  1  LCD controller busy with the previous bus word.
REQ-007 SHALL have port lcd_wr_en  output  1  one-cycle strobe launching one bus word.
REQ-008 SHALL have port lcd_rs  output  1  0 = register index, 1 = data; valid with lcd_wr_en.
REQ-009 SHALL have port lcd_data  output  16  bus word; valid with lcd_wr_en.
REQ-010 SHALL have port req  input  2  per-requester window request; level, held until gnt.
REQ-011 SHALL have port win0, win1  input  34 each  {x0[7:0], y0[8:0], x1[7:0], y1[8:0]}.
REQ-012 SHALL have port gnt  output  2  one-cycle grant pulse; window latched that cycle.
REQ-013 SHALL have port px_data0, px_data1  input  16 each  RGB565 pixel.
REQ-014 SHALL have port px_valid  input  2  pixel available.
REQ-015 SHALL have port px_ready  output  2  pixel accepted when px_valid and px_ready are both high.
REQ-016 SHALL have port done, err  output  2 each  one-cycle job-complete / job-rejected pulses.

Function
REQ-017 SHALL implement states IDLE, REG, HOLD, WAIT, PIX, PHOLD, PWAIT.
REQ-018 In IDLE with init_done=1 and any req bit set, SHALL grant round-robin: on a tie, grant the requester not granted last; after reset, requester 0 wins.
REQ-019 On grant, SHALL latch the window and compute count = (x1-x0+1)*(y1-y0+1), 17-bit unsigned.
REQ-020 If x0>x1, y0>y1, x1>X_MAX or y1>Y_MAX, SHALL pulse err for that requester the cycle after gnt, issue no bus words, and return to IDLE.
REQ-021 For a valid window, REG SHALL issue 17 words in order: index/data pairs for registers 0x02..0x09 (col start hi/lo, col end hi/lo, row start hi/lo, row end hi/lo; data = {8'h00, byte}), then index 0x22.
REQ-022 Each bus word SHALL be a one-cycle lcd_wr_en, issued only when lcd_busy=0; the next cycle (HOLD/PHOLD) SHALL ignore lcd_busy; WAIT/PWAIT SHALL then wait for lcd_busy=0.
REQ-023 In PIX with lcd_busy=0, SHALL assert px_ready for the granted requester only.
REQ-024 On each accepted pixel, SHALL drive lcd_wr_en=1, lcd_rs=1 and lcd_data=pixel on the next cycle, then decrement count.
REQ-025 When count reaches 0 after a pixel word, SHALL pulse done for the granted requester and return to IDLE.
REQ-026 A new grant SHALL occur no earlier than the cycle after done/err.
REQ-027 If init_done falls in any non-IDLE state, SHALL abort to IDLE within one cycle, deassert px_ready, and pulse err for the granted requester.
REQ-028 A req deasserted mid-job SHALL have no effect; the job completes.
REQ-029 lcd_wr_en, lcd_rs, lcd_data, gnt, done and err SHALL be registered outputs; px_ready SHALL be combinational from state and lcd_busy only.

Reset
REQ-030 While rst=0, SHALL force: state IDLE, lcd_wr_en=0, lcd_rs=0, lcd_data=16'h0000, gnt=0, px_ready=0, done=0, err=0, count=0, round-robin pointer = requester 1 last.
REQ-031 Reset asserted mid-job SHALL discard the job without emitting further bus words after release.

Structure
REQ-032 Register addresses 0x02..0x09 and 0x22, the win field offsets, and the state encoding SHALL live in shared package hx8352_pkg.
REQ-033 Arbitration SHALL be a separate sub-module rr_arbiter2 (req, grant-enable -> one-hot gnt, pointer update).

Verification
REQ-034 req=01, win0={0,0,1,1}, lcd_busy pulses 2 cycles per word -> 17 register words (2,0,3,0,4,0,5,1,6,0,7,0,8,0,9,1,0x22), then 4 pixel words, then done=01.
REQ-035 req=11 simultaneously from reset, both 1x1 windows -> gnt=01 first, then gnt=10 after done; both complete.
REQ-036 win1={10,0,5,0} -> err=10 the cycle after gnt, zero lcd_wr_en pulses.
REQ-037 win0={0,0,X_MAX,Y_MAX} with lcd_busy=0 throughout -> exactly 96017 lcd_wr_en pulses, then done=01.
REQ-038 px_valid held low for 50 cycles mid-job -> no lcd_wr_en during the gap; the stream resumes with correct data.
REQ-039 init_done dropped during PIX -> IDLE, px_ready=0, err pulse; rst=0 mid-REG -> all outputs at reset values immediately.
